mips_multicycle_ctrl: RTL and testbench

Multicycle control FSM for the MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. Each cycle it drives the ALU's 4-bit `control` code and the datapath enables, and it consumes the ALU `zero` flag to resolve `beq`. It sits between the instruction register (`opcode`/`funct`) and the datapath muxes, register file, memory and PC. It also keeps a retired-instruction counter.

---
 rtl/mips_multicycle_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl
// Purpose  : Multicycle MIPS control FSM with a retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic [3:0]       alu_control,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             iord,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [1:0]       pc_src,
    output logic             pc_write_en,
    output logic             retired,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] c_FETCH  = 4'd0;
    localparam logic [3:0] c_DECODE = 4'd1;
    localparam logic [3:0] c_MEMADR = 4'd2;
    localparam logic [3:0] c_MEMRD  = 4'd3;
    localparam logic [3:0] c_MEMWB  = 4'd4;
    localparam logic [3:0] c_MEMWR  = 4'd5;
    localparam logic [3:0] c_EXEC   = 4'd6;
    localparam logic [3:0] c_ALUWB  = 4'd7;
    localparam logic [3:0] c_BRANCH = 4'd8;
    localparam logic [3:0] c_JUMP   = 4'd9;
    localparam logic [3:0] c_ADDIEX = 4'd10;
    localparam logic [3:0] c_ADDIWB = 4'd11;

    localparam logic [5:0] c_OP_LW   = 6'b100011;
    localparam logic [5:0] c_OP_SW   = 6'b101011;
    localparam logic [5:0] c_OP_R    = 6'b000000;
    localparam logic [5:0] c_OP_BEQ  = 6'b000100;
    localparam logic [5:0] c_OP_J    = 6'b000010;
    localparam logic [5:0] c_OP_ADDI = 6'b001000;

    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_SLT = 4'b0111;

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic             w_funct_ok;
    logic [3:0]       w_funct_alu;
    logic [CNT_W-1:0] r_count;

    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_alu = c_ALU_ADD;
        case (funct)
            6'b100000: w_funct_alu = c_ALU_ADD;
            6'b100010: w_funct_alu = c_ALU_SUB;
            6'b100100: w_funct_alu = c_ALU_AND;
            6'b100101: w_funct_alu = c_ALU_OR;
            6'b101010: w_funct_alu = c_ALU_SLT;
            default:   w_funct_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = c_FETCH;
        case (r_state)
            c_FETCH: w_next = c_DECODE;
            c_DECODE: begin
                case (opcode)
                    c_OP_LW, c_OP_SW: w_next = c_MEMADR;
                    c_OP_R:           w_next = c_EXEC;
                    c_OP_BEQ:         w_next = c_BRANCH;
                    c_OP_J:           w_next = c_JUMP;
                    c_OP_ADDI:        w_next = c_ADDIEX;
                    default:          w_next = c_FETCH;
                endcase
            end
            // opcode is held by the IR, so it still distinguishes lw from sw here
            c_MEMADR: w_next = (opcode == c_OP_LW) ? c_MEMRD : c_MEMWR;
            c_MEMRD:  w_next = c_MEMWB;
            c_EXEC:   w_next = w_funct_ok ? c_ALUWB : c_FETCH;
            c_ADDIEX: w_next = c_ADDIWB;
            default:  w_next = c_FETCH;
        endcase
    end

    always_comb begin
        alu_control = c_ALU_ADD;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        iord        = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        pc_src      = 2'b00;
        pc_write_en = 1'b0;
        retired     = 1'b0;
        illegal     = 1'b0;
        if (!reset) begin
            case (r_state)
                c_FETCH: begin
                    mem_read    = 1'b1;
                    ir_write    = 1'b1;
                    alu_src_b   = 2'b01;
                    pc_write_en = 1'b1;
                end
                c_DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        c_OP_LW, c_OP_SW, c_OP_R, c_OP_BEQ, c_OP_J, c_OP_ADDI: illegal = 1'b0;
                        default: illegal = 1'b1;
                    endcase
                end
                c_MEMADR, c_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                c_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                c_MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    retired   = 1'b1;
                end
                c_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    retired    = 1'b1;
                end
                c_EXEC: begin
                    alu_src_a   = 1'b1;
                    alu_control = w_funct_alu;
                    illegal     = ~w_funct_ok;
                end
                c_ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    retired   = 1'b1;
                end
                c_ADDIWB: begin
                    reg_write = 1'b1;
                    retired   = 1'b1;
                end
                c_BRANCH: begin
                    alu_src_a   = 1'b1;
                    alu_control = c_ALU_SUB;
                    pc_src      = 2'b01;
                    pc_write_en = zero;
                    retired     = 1'b1;
                end
                c_JUMP: begin
                    pc_src      = 2'b10;
                    pc_write_en = 1'b1;
                    retired     = 1'b1;
                end
                default: begin
                    alu_control = c_ALU_ADD;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, retired};
        end
    end

    assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_ctrl
// Purpose  : Directed and randomized checks of the control FSM against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] alu;
        logic       sa;
        logic [1:0] sb;
        logic       mr, mw, irw, rw, iord, rdst, m2r;
        logic [1:0] psrc;
        logic       pwe, ret, ill;
    } ctl_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode, funct;
    logic        zero;
    ctl_t        act;
    logic [31:0] instr_count;
    ctl_t        act_w;
    logic [2:0]  instr_count_w;

    int          n_err = 0;
    int          n_chk = 0;
    int          model_count = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl u_dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .alu_control(act.alu), .alu_src_a(act.sa), .alu_src_b(act.sb),
        .mem_read(act.mr), .mem_write(act.mw), .ir_write(act.irw), .reg_write(act.rw),
        .iord(act.iord), .reg_dst(act.rdst), .mem_to_reg(act.m2r), .pc_src(act.psrc),
        .pc_write_en(act.pwe), .retired(act.ret), .illegal(act.ill),
        .instr_count(instr_count)
    );

    // Narrow counter copy, used only to observe wraparound
    mips_multicycle_ctrl #(.CNT_W(3)) u_dut_w (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .alu_control(act_w.alu), .alu_src_a(act_w.sa), .alu_src_b(act_w.sb),
        .mem_read(act_w.mr), .mem_write(act_w.mw), .ir_write(act_w.irw), .reg_write(act_w.rw),
        .iord(act_w.iord), .reg_dst(act_w.rdst), .mem_to_reg(act_w.m2r), .pc_src(act_w.psrc),
        .pc_write_en(act_w.pwe), .retired(act_w.ret), .illegal(act_w.ill),
        .instr_count(instr_count_w)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit op_legal(input logic [5:0] op);
        return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
    endfunction

    function automatic bit fn_legal(input logic [5:0] fn);
        return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    function automatic logic [3:0] fn_alu(input logic [5:0] fn);
        logic [3:0] a;
        a = 4'b0010;
        if (fn == 6'b100010) a = 4'b0110;
        if (fn == 6'b100100) a = 4'b0000;
        if (fn == 6'b100101) a = 4'b0001;
        if (fn == 6'b101010) a = 4'b0111;
        return a;
    endfunction

    function automatic int n_cycles(input logic [5:0] op, input logic [5:0] fn);
        if (!op_legal(op))   return 2;
        if (op == 6'b100011) return 5;
        if (op == 6'b000000) return fn_legal(fn) ? 4 : 3;
        if (op == 6'b000100 || op == 6'b000010) return 3;
        return 4;
    endfunction

    function automatic bit retires(input logic [5:0] op, input logic [5:0] fn);
        return op_legal(op) && !(op == 6'b000000 && !fn_legal(fn));
    endfunction

    function automatic ctl_t idle_ctl();
        ctl_t e;
        e = '0;
        e.alu = 4'b0010;
        return e;
    endfunction

    // Expected controls for cycle k (0 = fetch) of an instruction
    function automatic ctl_t model(input logic [5:0] op, input logic [5:0] fn,
                                   input int k, input logic z);
        ctl_t e;
        bit   last;
        e = idle_ctl();
        last = (k == n_cycles(op, fn) - 1);
        if (k == 0) begin
            e.mr = 1; e.irw = 1; e.sb = 2'b01; e.pwe = 1;
        end else if (k == 1) begin
            e.sb = 2'b11; e.ill = !op_legal(op);
        end else begin
            e.ret = last && retires(op, fn);
            case (op)
                6'b100011, 6'b101011: begin
                    if (k == 2) begin e.sa = 1; e.sb = 2'b10; end
                    else if (op == 6'b101011) begin e.mw = 1; e.iord = 1; end
                    else if (k == 3) begin e.mr = 1; e.iord = 1; end
                    else begin e.rw = 1; e.m2r = 1; end
                end
                6'b000000: begin
                    if (k == 2) begin
                        e.sa = 1;
                        e.alu = fn_alu(fn);
                        e.ill = !fn_legal(fn);
                    end else begin
                        e.rw = 1; e.rdst = 1;
                    end
                end
                6'b000100: begin
                    e.sa = 1; e.alu = 4'b0110; e.psrc = 2'b01; e.pwe = z;
                end
                6'b000010: begin
                    e.psrc = 2'b10; e.pwe = 1;
                end
                default: begin
                    if (k == 2) begin e.sa = 1; e.sb = 2'b10; end
                    else e.rw = 1;
                end
            endcase
        end
        return e;
    endfunction

    // Called just after a rising edge with the FSM in FETCH.
    // zmode: 0/1 forces zero, 2 randomizes it each cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode,
                             input string tag);
        int n;
        n = n_cycles(op, fn);
        for (int k = 0; k < n; k++) begin
            if (k == 0) begin
                opcode = 6'($urandom);
                funct  = 6'($urandom);
            end else begin
                opcode = op;
                funct  = fn;
            end
            zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            #3;
            check({tag, "_ctl"}, 64'(act), 64'(model(op, fn, k, zero)));
            check({tag, "_cnt"}, 64'(instr_count), 64'(model_count));
            @(posedge clk);
            #1;
        end
        if (retires(op, fn)) model_count++;
        check({tag, "_cnt_end"}, 64'(instr_count), 64'(model_count));
        check({tag, "_cnt_wrap"}, 64'(instr_count_w), 64'(model_count % 8));
    endtask

    logic [5:0] ops [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
    logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    initial begin
        logic [5:0] rop, rfn;
        reset  = 1'b1;
        opcode = 6'b100011;
        funct  = 6'b100000;
        zero   = 1'b1;
        repeat (2) @(posedge clk);
        #4;
        check("reset_ctl", 64'(act), 64'(idle_ctl()));
        check("reset_cnt", 64'(instr_count), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr(6'b000000, 6'b100010, 2, "sub");
        run_instr(6'b100011, 6'b000000, 2, "lw");
        run_instr(6'b101011, 6'b000000, 2, "sw");
        run_instr(6'b000100, 6'b000000, 1, "beq_t");
        run_instr(6'b000100, 6'b000000, 0, "beq_nt");
        run_instr(6'b000010, 6'b000000, 2, "j");
        run_instr(6'b001000, 6'b000000, 2, "addi");
        run_instr(6'b111111, 6'b100000, 2, "ill_op");
        run_instr(6'b000000, 6'b000000, 2, "ill_fn");
        check("directed_cnt", 64'(instr_count), 64'd7);

        // Abort a lw in MEMRD with reset
        opcode = 6'b100011;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #3;
        check("rst_memrd_ctl", 64'(act), 64'(idle_ctl()));
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_count = 0;
        check("rst_memrd_cnt", 64'(instr_count), 64'd0);
        run_instr(6'b001000, 6'b000000, 2, "post_rst");

        for (int i = 0; i < 300; i++) begin
            rop = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 5)] : 6'($urandom);
            rfn = ($urandom_range(0, 9) < 7) ? fns[$urandom_range(0, 4)] : 6'($urandom);
            run_instr(rop, rfn, 2, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
